// File: rtl/alu_mdu.sv
// EX-stage execute unit: a combinational ALU plus a multi-cycle multiply/divide
// unit that owns HI/LO and raises busy so the hazard logic can stall.
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] ALUout,
  output logic             Zero,
  input  logic [2:0]       MDUOp,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int SHW     = $clog2(WIDTH);
  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // ALU
  logic [SHW-1:0] shamt;
  assign shamt = B[SHW-1:0];

  always_comb begin
    ALUout = '0;
    case (ALUOp)
      4'd0:    ALUout = A + B;
      4'd1:    ALUout = A - B;
      4'd2:    ALUout = A & B;
      4'd3:    ALUout = A | B;
      4'd4:    ALUout = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'd5:    ALUout = A ^ B;
      4'd6:    ALUout = ~(A | B);
      4'd7:    ALUout = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd8:    ALUout = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd9:    ALUout = A << shamt;
      4'd10:   ALUout = A >> shamt;
      4'd11:   ALUout = $signed(A) >>> shamt;
      default: ALUout = '0;
    endcase
  end

  assign Zero = (A == B);

  // MDU
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               neg_a, neg_b, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, divisor, uq, ur, quot, rem;

  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Signed divide via magnitudes; MIN/-1 falls out as quotient MIN, remainder 0.
  assign neg_a   = (op_q == OP_DIV) & a_q[WIDTH-1];
  assign neg_b   = (op_q == OP_DIV) & b_q[WIDTH-1];
  assign mag_a   = neg_a ? -a_q : a_q;
  assign mag_b   = neg_b ? -b_q : b_q;
  assign b_zero  = (b_q == '0);
  assign divisor = b_zero ? WIDTH'(1) : mag_b;
  assign uq      = mag_a / divisor;
  assign ur      = mag_a % divisor;
  assign quot    = (neg_a ^ neg_b) ? -uq : uq;
  assign rem     = neg_a ? -ur : ur;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (MDUOp)
            OP_MULT, OP_MULTU: begin
              state_d = S_BUSY;
              cnt_d   = MUL_N;
              a_d     = A;
              b_d     = B;
              op_d    = MDUOp;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_BUSY;
              cnt_d   = DIV_N;
              a_d     = A;
              b_d     = B;
              op_d    = MDUOp;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
              if (!b_zero) begin
                hi_d = rem;
                lo_d = quot;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu: ALU sweep, MDU timing/results, ignore rules,
// reset abort, and a WIDTH=16 build.
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  alu_op = '0;
  logic [31:0] alu_out;
  logic        zero;
  logic [2:0]  mdu_op = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  alu_op16 = '0;
  logic [15:0] alu_out16;
  logic        zero16;
  logic [2:0]  mdu_op16 = '0;
  logic        start16 = 1'b0;
  logic        busy16;
  logic [15:0] hi16, lo16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(rst_n), .A(a), .B(b), .ALUOp(alu_op), .ALUout(alu_out),
    .Zero(zero), .MDUOp(mdu_op), .start(start), .busy(busy), .HI(hi), .LO(lo)
  );

  alu_mdu #(.WIDTH(16), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut16 (
    .clk(clk), .reset(rst_n), .A(a16), .B(b16), .ALUOp(alu_op16), .ALUout(alu_out16),
    .Zero(zero16), .MDUOp(mdu_op16), .start(start16), .busy(busy16), .HI(hi16), .LO(lo16)
  );

  // Drives one start strobe captured by the next posedge; returns #1 after it.
  task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    mdu_op = op; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 3'd0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b hi=%h lo=%h, expected 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu;
    logic [3:0]  ops[14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                             4'd9, 4'd10, 4'd11, 4'd13, 4'd15};
    logic [31:0] va[14]  = '{32'h7FFF_FFFF, 32'd5, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h5555_5555,
                             32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd3, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] vb[14]  = '{32'd1, 32'd7, 32'hFF00_FF00, 32'hFF00_FF00, 32'h0000_1234,
                             32'hFF00_FF00, 32'hFF00_FF00, 32'd1, 32'd1,
                             32'h21, 32'd4, 32'd4, 32'h1, 32'hFFFF_FFFF};
    logic [31:0] ve[14]  = '{32'h8000_0000, 32'hFFFF_FFFE, 32'hF000_F000, 32'hFFF0_FFF0,
                             32'h1234_0000, 32'h0FF0_0FF0, 32'h000F_000F, 32'd1, 32'd0,
                             32'd6, 32'h0800_0000, 32'hF800_0000, 32'd0, 32'd0};
    for (int i = 0; i < 14; i++) begin
      alu_op = ops[i]; a = va[i]; b = vb[i];
      #1;
      checks++;
      if (alu_out !== ve[i]) begin
        errors++;
        $display("FAIL alu op%0d: got %h, expected %h", ops[i], alu_out, ve[i]);
      end
    end
    a = 32'h0000_1234; b = 32'h0000_1234; #1;
    checks++;
    if (zero !== 1'b1) begin
      errors++;
      $display("FAIL zero_eq: got %b, expected 1", zero);
    end
    b = 32'h0000_1235; #1;
    checks++;
    if (zero !== 1'b0) begin
      errors++;
      $display("FAIL zero_ne: got %b, expected 0", zero);
    end
  endtask

  task automatic test_mult;
    int n;
    issue(3'd1, 32'hFFFF_FFFD, 32'd5);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL mult_hold: hi=%h lo=%h during busy, expected 0/0", hi, lo);
    end
    count_busy(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL mult_busy: %0d cycles, expected 5", n);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_res: hi=%h lo=%h, expected ffffffff/fffffff1", hi, lo);
    end
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu: n=%0d hi=%h lo=%h, expected 5/00000001/fffffffe", n, hi, lo);
    end
  endtask

  task automatic test_div;
    int n;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL div_busy: %0d cycles, expected 10", n);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_res: hi=%h lo=%h, expected ffffffff/fffffffd", hi, lo);
    end
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_ovf: hi=%h lo=%h, expected 00000000/80000000", hi, lo);
    end
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    checks++;
    if (hi !== 32'h1 || lo !== 32'h7FFF_FFFC) begin
      errors++;
      $display("FAIL divu: hi=%h lo=%h, expected 00000001/7ffffffc", hi, lo);
    end
    issue(3'd5, 32'hAA, 32'd0);
    issue(3'd6, 32'hBB, 32'd0);
    issue(3'd4, 32'd1234, 32'd0);
    count_busy(n);
    checks++;
    if (n !== 10 || hi !== 32'hAA || lo !== 32'hBB) begin
      errors++;
      $display("FAIL div_by0: n=%0d hi=%h lo=%h, expected 10/000000aa/000000bb", n, hi, lo);
    end
  endtask

  task automatic test_ignore;
    logic busy_ok = 1'b1;
    issue(3'd3, 32'd100, 32'd7);
    for (int k = 1; k <= 10; k++) begin
      start  = (k == 3 || k == 10);
      mdu_op = start ? 3'd1 : 3'd0;
      a = 32'd3; b = 32'd4;
      @(posedge clk); #1;
      if (k < 10 && busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0; mdu_op = 3'd0;
    checks++;
    if (!busy_ok || busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL ignore_start: busy_ok=%b busy=%b hi=%h lo=%h, expected 1/0/2/14",
               busy_ok, busy, hi, lo);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL ignore_after: busy=%b hi=%h lo=%h, expected 0/2/14", busy, hi, lo);
    end
  endtask

  task automatic test_reset_abort;
    issue(3'd3, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL abort_now: busy=%b hi=%h lo=%h, expected 0/0/0", busy, hi, lo);
    end
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL abort_late: busy=%b hi=%h lo=%h, expected 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo;
    logic seen_busy = 1'b0;
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd5; a = 32'h11;
    @(posedge clk); #1;
    if (busy !== 1'b0) seen_busy = 1'b1;
    mdu_op = 3'd6; a = 32'h22;
    @(posedge clk); #1;
    if (busy !== 1'b0) seen_busy = 1'b1;
    mdu_op = 3'd0; a = 32'h33;
    @(posedge clk); #1;
    if (busy !== 1'b0) seen_busy = 1'b1;
    mdu_op = 3'd7;
    @(posedge clk); #1;
    if (busy !== 1'b0) seen_busy = 1'b1;
    start = 1'b0; mdu_op = 3'd0;
    checks++;
    if (seen_busy || hi !== 32'h11 || lo !== 32'h22) begin
      errors++;
      $display("FAIL mthi_mtlo: busy_seen=%b hi=%h lo=%h, expected 0/11/22", seen_busy, hi, lo);
    end
  endtask

  task automatic test_w16;
    int n = 0;
    @(negedge clk);
    mdu_op16 = 3'd1; a16 = 16'h00FF; b16 = 16'h0101; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; mdu_op16 = 3'd0; a16 = 16'h1234; b16 = 16'h5678;
    while (busy16 === 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 5 || hi16 !== 16'h0000 || lo16 !== 16'hFFFF) begin
      errors++;
      $display("FAIL w16_mult: n=%0d hi=%h lo=%h, expected 5/0000/ffff", n, hi16, lo16);
    end
    alu_op16 = 4'd4; b16 = 16'h0012; #1;
    checks++;
    if (alu_out16 !== 16'h1200) begin
      errors++;
      $display("FAIL w16_lui: got %h, expected 1200", alu_out16);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_ignore();
    test_reset_abort();
    test_mthi_mtlo();
    test_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
